// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core front end.
// Contents:
//   RESET_PC       byte address of the first fetch after reset
//   NOP_INSTR      bubble instruction (addi x0,x0,0)
//   fetch_state_t  fetch FSM encoding (BOOT / RUN / HALT)
package rv32i_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   load              capture fetch_pc / fetch_instr as a valid instruction
//   flush             replace the held instruction with a bubble (wins over load)
//   fetch_pc          PC of the instruction being captured
//   fetch_instr       instruction word from the SRAM
//   id_valid/id_pc/id_pc_plus4/id_instr  registered outputs to decode
// Neither load nor flush: contents are held (stall).
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BUBBLE     = rv32i_pkg::NOP_INSTR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  flush,
    input  logic [31:0]           fetch_pc,
    input  logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  id_valid,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_pc_plus4,
    output logic [DATA_WIDTH-1:0] id_instr
);

    // Pipeline register: flush beats load; a flush keeps id_pc so id_pc_plus4 stays consistent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0004;
            id_instr    <= BUBBLE;
        end else if (flush) begin
            id_valid    <= 1'b0;
            id_instr    <= BUBBLE;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_pc       <= fetch_pc;
            id_pc_plus4 <= fetch_pc + 32'd4;
            id_instr    <= fetch_instr;
        end else begin
            id_valid    <= id_valid;
            id_pc       <= id_pc;
            id_pc_plus4 <= id_pc_plus4;
            id_instr    <= id_instr;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the instruction SRAM
// (combinational read) and loads the IF/ID register.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   stall                     hold PC and IF/ID
//   redirect_valid/_target    taken branch/jump; flushes IF/ID, exits HALT
//   halt_req                  stop fetching (enter HALT)
//   imem_addr / imem_rdata    SRAM word address (pc[ADDR_WIDTH+1:2]) and read data
//   pc                        current fetch PC
//   id_valid, id_pc, id_pc_plus4, id_instr   IF/ID register contents
//   misalign_fault            sticky: a redirect target was not word aligned
//   halted                    FSM is in HALT
// Optional: define IF_PERF_CNT_EN to add fetch_count / stall_count outputs.
module if_fetch_stage #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [31:0]           RESET_PC   = rv32i_pkg::RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = rv32i_pkg::NOP_INSTR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_target,
    input  logic                  halt_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [31:0]           pc,
    output logic                  id_valid,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_pc_plus4,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic                  misalign_fault,
    output logic                  halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    import rv32i_pkg::*;

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic         misalign_r;
    logic         halted_r;
    logic         load_s;
    logic         flush_s;
    logic         misalign_set_s;
    logic         stall_cycle_s;

    // Next-state / control decode: redirect > halt_req > stall > advance.
    always_comb begin
        state_next_s   = state_r;
        pc_next_s      = pc_r;
        load_s         = 1'b0;
        flush_s        = 1'b0;
        misalign_set_s = 1'b0;
        stall_cycle_s  = 1'b0;
        case (state_r)
            FETCH_BOOT: begin
                // Single bubble cycle after reset release; pc and IF/ID hold.
                state_next_s = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redirect_valid) begin
                    pc_next_s      = {redirect_target[31:2], 2'b00};
                    flush_s        = 1'b1;
                    misalign_set_s = (redirect_target[1:0] != 2'b00);
                end else if (halt_req) begin
                    state_next_s = FETCH_HALT;
                    flush_s      = 1'b1;
                end else if (stall) begin
                    stall_cycle_s = 1'b1;
                end else begin
                    load_s    = 1'b1;
                    pc_next_s = pc_r + 32'd4;
                end
            end
            FETCH_HALT: begin
                flush_s = 1'b1;
                if (redirect_valid) begin
                    state_next_s   = FETCH_RUN;
                    pc_next_s      = {redirect_target[31:2], 2'b00};
                    misalign_set_s = (redirect_target[1:0] != 2'b00);
                end else begin
                    state_next_s = FETCH_HALT;
                end
            end
            default: begin
                // Unreachable encoding: recover through BOOT with a bubble.
                state_next_s = FETCH_BOOT;
                flush_s      = 1'b1;
            end
        endcase
    end

    // PC, FSM state, sticky misalign flag and halted flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= FETCH_BOOT;
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            misalign_r <= misalign_r | misalign_set_s;
            halted_r   <= (state_next_s == FETCH_HALT);
        end
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUBBLE     (NOP_INSTR)
    ) u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .load        (load_s),
        .flush       (flush_s),
        .fetch_pc    (pc_r),
        .fetch_instr (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_r;
    logic [31:0] stall_count_r;

    // Performance counters: advances and pure stall cycles, wrapping modulo 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            fetch_count_r <= fetch_count_r + {31'd0, load_s};
            stall_count_r <= stall_count_r + {31'd0, stall_cycle_s};
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`endif

    // Word address simply truncates the PC, so fetch wraps at the SRAM size.
    assign imem_addr      = pc_r[ADDR_WIDTH+1:2];
    assign pc             = pc_r;
    assign misalign_fault = misalign_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the stimulus process pushes the expected
// post-edge state, a monitor pops and compares it on the following falling edge.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        misalign_fault;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] idpc;
        logic [31:0] instr;
        logic        mis;
        logic        hlt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    if_fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc              (pc),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_instr        (id_instr),
        .misalign_fault  (misalign_fault),
        .halted          (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    assign imem_rdata = mem[imem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare the DUT against the oldest expected snapshot.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] e_addr;
            e = q.pop_front();
            e_addr = {22'd0, e.pc[11:2]};
            chk("pc",             pc,                 e.pc);
            chk("imem_addr",      {22'd0, imem_addr}, e_addr);
            chk("id_valid",       {31'd0, id_valid},  {31'd0, e.v});
            chk("id_pc",          id_pc,              e.idpc);
            chk("id_pc_plus4",    id_pc_plus4,        e.idpc + 32'd4);
            chk("id_instr",       id_instr,           e.instr);
            chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, e.mis});
            chk("halted",         {31'd0, halted},    {31'd0, e.hlt});
        end
    end

    task automatic push(input logic [31:0] epc, input logic ev, input logic [31:0] eidpc,
                        input logic [31:0] einstr, input logic emis, input logic ehlt);
        exp_t e;
        e.pc = epc; e.v = ev; e.idpc = eidpc; e.instr = einstr; e.mis = emis; e.hlt = ehlt;
        q.push_back(e);
    endtask

    // One clock edge with the given inputs, then the expected state after it.
    task automatic step(input logic st, input logic rv, input logic [31:0] tg, input logic hr,
                        input logic [31:0] epc, input logic ev, input logic [31:0] eidpc,
                        input logic [31:0] einstr, input logic emis, input logic ehlt);
        stall = st; redirect_valid = rv; redirect_target = tg; halt_req = hr;
        @(posedge clock);
        #1;
        push(epc, ev, eidpc, einstr, emis, ehlt);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = NOP;
        mem[0]    = 32'h01100F13;
        mem[1]    = 32'h00000E33;
        mem[2]    = 32'h00100E93;
        mem[3]    = 32'h00000393;
        mem[4]    = 32'h00100313;
        mem[5]    = 32'h000382B3;
        mem[6]    = 32'h00030393;
        mem[7]    = 32'h00028313;
        mem[8]    = 32'hFFCF02E3;
        mem[1023] = 32'h00A00093;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'd0; halt_req = 1'b0;
        push(32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // BOOT bubble, then free-run
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h00, NOP,          1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h04, 1'b1, 32'h00, 32'h01100F13, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h08, 1'b1, 32'h04, 32'h00000E33, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0C, 1'b1, 32'h08, 32'h00100E93, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0C, 32'h00000393, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, 32'h10, 32'h00100313, 1'b0, 1'b0);
        // stall for three cycles at pc=0x14
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, 32'h10, 32'h00100313, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h18, 1'b1, 32'h14, 32'h000382B3, 1'b0, 1'b0);
        // redirect with stall high: redirect wins
        step(1'b1, 1'b1, 32'h20, 1'b0, 32'h20, 1'b0, 32'h14, NOP,         1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 1'b1, 32'h20, 32'hFFCF02E3, 1'b0, 1'b0);
        // misaligned redirect: sticky fault, target aligned down
        step(1'b0, 1'b1, 32'h22, 1'b0, 32'h20, 1'b0, 32'h20, NOP,         1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 1'b1, 32'h20, 32'hFFCF02E3, 1'b1, 1'b0);
        // halt at pc=0x8
        step(1'b0, 1'b1, 32'h08, 1'b0, 32'h08, 1'b0, 32'h20, NOP, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, 32'h20, NOP, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 1'b0, 32'h20, NOP, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b0, 32'h20, NOP, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0, 32'h20, NOP, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h04, 1'b1, 32'h00, 32'h01100F13, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, 32'h04, 32'h00000E33, 1'b1, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count_run", fetch_count, 32'd10);
        chk("stall_count_run", stall_count, 32'd3);
`endif
        // asynchronous reset between edges
        @(posedge clock);
        #2;
        reset = 1'b1;
        push(32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0);
        #1;
        chk("async_reset_pc", pc, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count_reset", fetch_count, 32'd0);
        chk("stall_count_reset", stall_count, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h00, NOP,          1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h04, 1'b1, 32'h00, 32'h01100F13, 1'b0, 1'b0);
        // PC wrap from 0xFFFFFFFC; id_pc_plus4 wraps to 0
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h00, NOP, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h00A00093, 1'b0, 1'b0);
        // halt beats stall; redirect beats halt_req in HALT
        step(1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'hFFFF_FFFC, NOP, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h04, 1'b1, 32'h04, 1'b0, 32'hFFFF_FFFC, NOP, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, 32'h04, 32'h00000E33, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count_end", fetch_count, 32'd3);
        chk("stall_count_end", stall_count, 32'd0);
`endif
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
